// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between the I-cache and D-cache refill FSMs.
// Ownership is granted for a whole burst and held until every read it issued has returned.
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_read_req,
  input  logic [15:0] ic_addr,
  output logic        ic_pause,
  output logic        ic_data_vld,
  output logic [15:0] ic_data,
  input  logic        dc_read_req,
  input  logic        dc_wrt,
  input  logic [15:0] dc_addr,
  input  logic [15:0] dc_wdata,
  output logic        dc_pause,
  output logic        dc_data_vld,
  output logic [15:0] dc_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid
);

  // The 3-bit outstanding counter cannot track more than 7 reads in flight.
  if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be within 1..7");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IC_OWN = 2'd1;
  localparam logic [1:0] S_DC_OWN = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IC   = 2'd1;
  localparam logic [1:0] OWN_DC   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [2:0] out_cnt_q, out_cnt_d;

  logic dc_req;
  logic rd_issue;
  logic rd_ret;

  assign dc_req = dc_read_req | dc_wrt;

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    ic_pause  = ic_read_req;
    dc_pause  = dc_req;
    case (state_q)
      S_IC_OWN: begin
        mem_en   = ic_read_req;
        mem_addr = ic_addr;
        ic_pause = 1'b0;
      end
      S_DC_OWN: begin
        mem_en    = dc_req;
        mem_wr    = dc_wrt;
        mem_addr  = dc_addr;
        mem_wdata = dc_wdata;
        dc_pause  = 1'b0;
      end
      default: ;
    endcase
  end

  // A return with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
  assign rd_issue = mem_en & ~mem_wr;
  assign rd_ret   = mem_data_valid & (out_cnt_q != 3'd0);

  assign ic_data_vld = rd_ret & (owner_q == OWN_IC);
  assign dc_data_vld = rd_ret & (owner_q == OWN_DC);
  assign ic_data     = mem_data_in;
  assign dc_data     = mem_data_in;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (rd_issue && !rd_ret) begin
      out_cnt_d = out_cnt_q + 3'd1;
    end else if (!rd_issue && rd_ret) begin
      out_cnt_d = out_cnt_q - 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (dc_req) begin
          state_d = S_DC_OWN;
          owner_d = OWN_DC;
        end else if (ic_read_req) begin
          state_d = S_IC_OWN;
          owner_d = OWN_IC;
        end
      end
      S_IC_OWN: begin
        if (!ic_read_req) begin
          state_d = (out_cnt_d == 3'd0) ? S_IDLE : S_DRAIN;
        end
      end
      S_DC_OWN: begin
        if (!dc_req) begin
          state_d = (out_cnt_d == 3'd0) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_cnt_d == 3'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      out_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule
